// File: rtl/stack_port_master.sv
// stack_port_master: turns push/pop commands into the Stack's shared-bus
// enable/push_pop/data_io handshake. Owns bus turnaround, refuses pushes
// into a full Stack or pops from an empty one, and keeps a shadow
// occupancy count.
module stack_port_master #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 1024,
  parameter int TURN_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       stk_enable,
  output logic                       stk_push_pop,
  inout  wire  [DATA_W-1:0]          stk_data_io,
  input  logic                       stk_full,
  input  logic                       stk_empty
);

  localparam int               OCC_W     = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(DEPTH);
  localparam logic [1:0]       TURN_LAST = 2'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PUSH, TURN, POP, CAP, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        turn_count;
  logic [DATA_W-1:0] push_word;
  logic              err_flag;
  logic              drive;
  logic              accept;
  logic              refuse;

  assign accept = cmd_valid && cmd_ready;
  // A pop into an empty Stack or a push into a full one never touches the bus.
  assign refuse = cmd_op ? stk_empty : stk_full;

  // State register; reset abandons any in-flight command silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing through the push or turnaround/pop/capture path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (refuse)      state_next = RESP;
          else if (cmd_op) state_next = TURN;
          else             state_next = PUSH;
        end
      end
      PUSH:    state_next = RESP;
      TURN:    if (turn_count == TURN_LAST) state_next = POP;
      POP:     state_next = CAP;
      CAP:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: Stack strobes, bus ownership and response handshake.
  always_comb begin
    cmd_ready    = (state == IDLE) && !rst;
    rsp_valid    = (state == RESP);
    rsp_err      = (state == RESP) && err_flag;
    stk_enable   = (state == PUSH) || (state == POP);
    stk_push_pop = (state == TURN) || (state == POP) || (state == CAP);
    drive        = (state == PUSH);
  end

  // Counts released-bus cycles spent in TURN before the pop strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                turn_count <= '0;
    else if (state == TURN) turn_count <= turn_count + 2'd1;
    else                    turn_count <= '0;
  end

  // Command latch, popped-word capture and saturating shadow occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_word <= '0;
      err_flag  <= 1'b0;
      rsp_data  <= '0;
      occupancy <= '0;
    end else begin
      if (accept) begin
        push_word <= cmd_data;
        err_flag  <= refuse;
      end
      if (state == PUSH && occupancy != OCC_MAX) occupancy <= occupancy + 1'b1;
      if (state == POP && occupancy != '0)       occupancy <= occupancy - 1'b1;
      if (state == CAP)                          rsp_data  <= stk_data_io;
    end
  end

  assign stk_data_io = drive ? push_word : 'z;

endmodule

// File: tb/tb_stack_port_master.sv
// tb_stack_port_master: two masters (TURN_CYCLES 1 and 3) each attached to a
// behavioural Stack device, checked every cycle against a command-level
// reference model of expected responses, strobes, occupancy and bus use.
module tb_stack_port_master;

  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int OW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      cmd_valid = '0;
  logic [1:0]      cmd_op = '0;
  logic [2*DW-1:0] cmd_data = '0;
  wire  [1:0]      cmd_ready, rsp_valid, rsp_err, stk_enable, stk_push_pop;
  wire  [2*DW-1:0] rsp_data;
  wire  [2*OW-1:0] occupancy;
  wire  [DW-1:0]   bus0, bus1;

  // Behavioural Stack devices
  logic [DW-1:0] smem [2][DEPTH];
  int            sp [2] = '{0, 0};
  logic [1:0]    stk_drv = '0;
  logic [DW-1:0] stk_out [2];
  wire  [1:0]    stk_full  = {sp[1] >= DEPTH, sp[0] >= DEPTH};
  wire  [1:0]    stk_empty = {sp[1] == 0, sp[0] == 0};

  assign bus0 = stk_drv[0] ? stk_out[0] : 'z;
  assign bus1 = stk_drv[1] ? stk_out[1] : 'z;

  // Reference model: contents seen from the command side, plus per-command expectations
  typedef struct {
    int            rsp_cyc;
    int            en_cyc;
    int            pp_lo;
    int            pp_hi;
    int            drv_cyc;
    int            chg_cyc;
    int            occ_old;
    int            occ_new;
    logic          err;
    logic [DW-1:0] word;
    logic [DW-1:0] dat_old;
    logic [DW-1:0] dat_new;
  } exp_t;

  exp_t          ex [2];
  logic [DW-1:0] rq [2][DEPTH];
  int            rn [2] = '{0, 0};

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] bv, rdv;
  logic [OW-1:0] occv;
  logic          mdrv;

  stack_port_master #(.DATA_W(DW), .DEPTH(DEPTH), .TURN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_data(cmd_data[DW-1:0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_data(rsp_data[DW-1:0]),
    .occupancy(occupancy[OW-1:0]),
    .stk_enable(stk_enable[0]), .stk_push_pop(stk_push_pop[0]), .stk_data_io(bus0),
    .stk_full(stk_full[0]), .stk_empty(stk_empty[0])
  );

  stack_port_master #(.DATA_W(DW), .DEPTH(DEPTH), .TURN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_data(cmd_data[2*DW-1:DW]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_data(rsp_data[2*DW-1:DW]),
    .occupancy(occupancy[2*OW-1:OW]),
    .stk_enable(stk_enable[1]), .stk_push_pop(stk_push_pop[1]), .stk_data_io(bus1),
    .stk_full(stk_full[1]), .stk_empty(stk_empty[1])
  );

  always #5 clk = ~clk;

  // Edge counter used to time every expectation
  always @(posedge clk) cyc <= cyc + 1;

  // Stack device: samples on enabled edges, drives the popped word the cycle after
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      stk_drv[i] <= 1'b0;
      if (stk_enable[i]) begin
        if (!stk_push_pop[i]) begin
          if (sp[i] < DEPTH) begin
            smem[i][sp[i]] <= (i == 0) ? bus0 : bus1;
            sp[i]          <= sp[i] + 1;
          end
        end else if (sp[i] > 0) begin
          stk_out[i] <= smem[i][sp[i]-1];
          sp[i]      <= sp[i] - 1;
          stk_drv[i] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got 0x%0h, want 0x%0h", name, i, cyc, got, want);
    end
  endtask

  // Per-cycle compare of both masters against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bv   = (i == 0) ? bus0 : bus1;
      rdv  = rsp_data[i*DW +: DW];
      occv = occupancy[i*OW +: OW];
      if (rst) begin
        check("reset_ready",     i, 32'(cmd_ready[i]),    32'd0);
        check("reset_rsp_valid", i, 32'(rsp_valid[i]),    32'd0);
        check("reset_rsp_err",   i, 32'(rsp_err[i]),      32'd0);
        check("reset_rsp_data",  i, 32'(rdv),             32'd0);
        check("reset_occupancy", i, 32'(occv),            32'd0);
        check("reset_enable",    i, 32'(stk_enable[i]),   32'd0);
        check("reset_push_pop",  i, 32'(stk_push_pop[i]), 32'd0);
      end else begin
        check("cmd_ready", i, 32'(cmd_ready[i]), 32'(cyc > ex[i].rsp_cyc));
        check("rsp_valid", i, 32'(rsp_valid[i]), 32'(cyc == ex[i].rsp_cyc));
        if (rsp_valid[i] && cyc == ex[i].rsp_cyc)
          check("rsp_err", i, 32'(rsp_err[i]), 32'(ex[i].err));
        check("rsp_data", i, 32'(rdv), 32'((cyc >= ex[i].rsp_cyc) ? ex[i].dat_new : ex[i].dat_old));
        check("occupancy", i, 32'(occv), 32'((cyc >= ex[i].chg_cyc) ? ex[i].occ_new : ex[i].occ_old));
        check("stk_enable", i, 32'(stk_enable[i]), 32'(cyc == ex[i].en_cyc));
        check("stk_push_pop", i, 32'(stk_push_pop[i]), 32'(cyc >= ex[i].pp_lo && cyc <= ex[i].pp_hi));
      end
      mdrv = !rst && (cyc == ex[i].drv_cyc);
      if (stk_drv[i])
        check("bus_contention", i, 32'(bv), 32'(stk_out[i]));
      else if (mdrv)
        check("bus_push_word", i, 32'(bv), 32'(ex[i].word));
      else
        check("bus_released", i, 32'($isunknown(bv) || bv == '0), 32'd1);
    end
  end

  task automatic clear_model(input int i);
    ex[i].rsp_cyc = -100;
    ex[i].en_cyc  = -100;
    ex[i].pp_lo   = -100;
    ex[i].pp_hi   = -101;
    ex[i].drv_cyc = -100;
    ex[i].chg_cyc = -100;
    ex[i].occ_old = 0;
    ex[i].occ_new = 0;
    ex[i].err     = 1'b0;
    ex[i].word    = '0;
    ex[i].dat_old = '0;
    ex[i].dat_new = '0;
    rn[i]         = 0;
  endtask

  // Asserts reset mid-cycle; callers are aligned just after a falling edge
  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) clear_model(i);
    repeat (2) begin @(negedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic issue_cmd(input int i, input logic op, input logic [DW-1:0] d, input bit wait_done,
                           output logic seen, output logic got_err, output logic [DW-1:0] got_data);
    int n;
    int a;
    int t;
    seen     = 1'b0;
    got_err  = 1'b0;
    got_data = '0;
    t = (i == 0) ? 1 : 3;
    n = 0;
    while (!cmd_ready[i] && n < 20) begin @(negedge clk); #1; n++; end
    if (!cmd_ready[i]) begin
      check("cmd_ready_timeout", i, 32'd0, 32'd1);
      return;
    end
    a = cyc + 1;
    ex[i].dat_old = ex[i].dat_new;
    ex[i].occ_old = rn[i];
    ex[i].occ_new = rn[i];
    ex[i].err     = 1'b0;
    ex[i].en_cyc  = -100;
    ex[i].pp_lo   = -100;
    ex[i].pp_hi   = -101;
    ex[i].drv_cyc = -100;
    ex[i].chg_cyc = a;
    ex[i].word    = d;
    if ((!op && rn[i] >= DEPTH) || (op && rn[i] == 0)) begin
      ex[i].rsp_cyc = a;
      ex[i].err     = 1'b1;
    end else if (!op) begin
      rq[i][rn[i]]  = d;
      rn[i]++;
      ex[i].rsp_cyc = a + 1;
      ex[i].en_cyc  = a;
      ex[i].drv_cyc = a;
      ex[i].chg_cyc = a + 1;
      ex[i].occ_new = rn[i];
    end else begin
      rn[i]--;
      ex[i].dat_new = rq[i][rn[i]];
      ex[i].rsp_cyc = a + t + 2;
      ex[i].en_cyc  = a + t;
      ex[i].pp_lo   = a;
      ex[i].pp_hi   = a + t + 1;
      ex[i].chg_cyc = a + t + 1;
      ex[i].occ_new = rn[i];
    end
    cmd_valid[i]         = 1'b1;
    cmd_op[i]            = op;
    cmd_data[i*DW +: DW] = d;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    if (!wait_done) return;
    n = 0;
    while (cyc <= ex[i].rsp_cyc && n < 20) begin
      @(negedge clk); #1; n++;
      if (rsp_valid[i]) begin
        seen     = 1'b1;
        got_err  = rsp_err[i];
        got_data = rsp_data[i*DW +: DW];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          s, e;
    logic [DW-1:0] dt;
    logic [DW-1:0] exp_pop [3];
    exp_pop = '{8'h04, 8'h02, 8'h00};

    @(negedge clk); #1;
    apply_reset();

    // Reset in the middle of a pop (during the capture cycle)
    issue_cmd(0, 1'b0, 8'h3C, 1'b1, s, e, dt);
    issue_cmd(0, 1'b1, 8'h00, 1'b0, s, e, dt);
    while (cyc < ex[0].pp_hi) begin @(negedge clk); #1; end
    apply_reset();
    check("pin_occ_after_reset", 0, 32'(occupancy[OW-1:0]), 32'd0);

    // Three back-to-back pushes, then three pops
    for (int k = 0; k < 3; k++) begin
      issue_cmd(0, 1'b0, 8'(2*k), 1'b1, s, e, dt);
      check("pin_push_ok", 0, 32'({s, e}), 32'b10);
    end
    check("pin_occ_three", 0, 32'(occupancy[OW-1:0]), 32'd3);
    for (int k = 0; k < 3; k++) begin
      issue_cmd(0, 1'b1, 8'h00, 1'b1, s, e, dt);
      check("pin_pop_data", 0, 32'(dt), 32'(exp_pop[k]));
    end
    check("pin_occ_zero", 0, 32'(occupancy[OW-1:0]), 32'd0);

    // Pop from empty is refused
    issue_cmd(0, 1'b1, 8'h00, 1'b1, s, e, dt);
    check("pin_pop_empty", 0, 32'({s, e}), 32'b11);

    // Longer turnaround: push then pop
    issue_cmd(1, 1'b0, 8'hA5, 1'b1, s, e, dt);
    issue_cmd(1, 1'b1, 8'h00, 1'b1, s, e, dt);
    check("pin_turn3_pop", 1, 32'(dt), 32'hA5);

    // Randomized traffic on both masters
    for (int k = 0; k < 60; k++) begin
      issue_cmd(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, s, e, dt);
      issue_cmd(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, s, e, dt);
    end
    while (rn[0] > 0) issue_cmd(0, 1'b1, 8'h00, 1'b1, s, e, dt);

    // Fill to capacity, then push into full, then pop the last word
    for (int k = 0; k < DEPTH; k++) issue_cmd(0, 1'b0, 8'(2*k), 1'b1, s, e, dt);
    check("pin_occ_full", 0, 32'(occupancy[OW-1:0]), 32'd1024);
    issue_cmd(0, 1'b0, 8'h55, 1'b1, s, e, dt);
    check("pin_push_full", 0, 32'({s, e}), 32'b11);
    check("pin_occ_still_full", 0, 32'(occupancy[OW-1:0]), 32'd1024);
    issue_cmd(0, 1'b1, 8'h00, 1'b1, s, e, dt);
    check("pin_pop_last", 0, 32'(dt), 32'hFE);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_port_master.md
Name: stack_port_master

Overview:
Bus master for the Stack block's shared bidirectional data port. Converts a simple command/response interface (push word / pop word) into the Stack's enable/push_pop/data_io protocol. It owns bus turnaround on data_io and guards against pushing when the Stack is full or popping when it is empty. It also keeps a shadow occupancy count. Sits between a controller FSM or CPU-side logic and one Stack instance.

Parameters:
DATA_W, 8, width of a stack word and of data_io
DEPTH, 1024, Stack capacity, which sizes the occupancy counter
TURN_CYCLES, 1, idle cycles with data_io released before a pop (range 1..3)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  master can accept a command
cmd_op  input  1  0 = push, 1 = pop
cmd_data  input  DATA_W  word to push; ignored for pop
rsp_valid  output  1  one-cycle pulse: command finished
rsp_err  output  1  qualifies rsp_valid: command refused (full/empty)
rsp_data  output  DATA_W  popped word, valid with rsp_valid on a good pop
occupancy  output  clog2(DEPTH+1)  shadow count of words in the Stack
stk_enable  output  1  Stack enable, active high
stk_push_pop  output  1  0 = push, 1 = pop
stk_data_io  inout  DATA_W  shared data bus; master drives only during a push
stk_full  input  1  Stack full flag
stk_empty  input  1  Stack empty flag

Behaviour:
- Stack protocol (fixed):
  - Stack samples on the rising clk edge when stk_enable=1.
  - Push: push_pop=0 and the master drives data_io.
  - Pop: push_pop=1. The Stack drives the popped word on data_io in the cycle after the pop cycle, while push_pop stays 1.
- Reset (asynchronous, any state including mid-operation):
  - State=IDLE; cmd_ready=0 while rst=1, then 1 in IDLE.
  - rsp_valid=0, rsp_err=0, rsp_data=0, occupancy=0.
  - stk_enable=0, stk_push_pop=0, data_io released (Z).
  - An in-flight command is dropped with no response.
- States: IDLE, PUSH, TURN, POP, CAP, RESP.
- IDLE: cmd_ready=1, stk_enable=0, bus released. On cmd_valid&cmd_ready, stk_full/stk_empty are sampled at the accepting edge:
  - push with stk_full=1, or pop with stk_empty=1 -> RESP with err=1. No Stack access; occupancy unchanged.
  - push otherwise -> latch cmd_data, go to PUSH.
  - pop otherwise -> TURN.
- PUSH (1 cycle): stk_enable=1, push_pop=0, data_io=latched word. Then -> RESP; occupancy+1.
- TURN (TURN_CYCLES cycles): stk_enable=0, push_pop=1, bus released. Then -> POP.
- POP (1 cycle): stk_enable=1, push_pop=1. Then -> CAP; occupancy-1.
- CAP (1 cycle): stk_enable=0, push_pop=1. data_io is captured into rsp_data at the end of CAP. Then -> RESP.
- RESP (1 cycle): rsp_valid=1, rsp_err per outcome. push_pop=0, bus still released (this is the turnaround cycle). cmd_ready=0. Then -> IDLE.
- Latency, command accepted at edge N:
  - push: rsp_valid in cycle N+2.
  - pop: rsp_valid in cycle N+TURN_CYCLES+3.
  - refused command: rsp_valid in cycle N+1.
- rsp_data holds its last good pop value; it is unchanged on push or error responses.
- Responses have no backpressure. One command is outstanding at a time.
- The master never drives data_io in any cycle where stk_push_pop=1, nor in the cycle after push_pop falls.
- occupancy saturates at 0 and DEPTH. A disagreement with the flags (e.g. stk_empty=1 while occupancy>0) has no effect on operation; it is a verification check only.

Test Plan:
- Reset mid-pop (rst during CAP) -> next cycle: stk_enable=0, data_io=Z, occupancy=0, no rsp_valid; the next command is accepted normally.
- Push 0x00,0x02,0x04 back-to-back into an empty Stack model -> three rsp_valid pulses with err=0, each 2 cycles after accept; occupancy=3; data_io driven only in PUSH cycles.
- Pop three times after the previous scenario -> rsp_data 0x04,0x02,0x00, each rsp_valid 4 cycles after accept (TURN_CYCLES=1); occupancy=0; push_pop=1 throughout TURN/POP/CAP.
- Pop when stk_empty=1 -> rsp_valid with rsp_err=1 one cycle after accept; stk_enable never asserted; occupancy stays 0.
- Fill 1024 words (value 2*i mod 256), then push 0x55 with stk_full=1 -> err=1, occupancy=1024. Then pop -> rsp_data=0xFE (2*1023 mod 256).
- TURN_CYCLES=3 with push-then-pop -> 3 released cycles before POP; a bus monitor sees no cycle with both master and Stack driving data_io.
